// File: rtl/register_bank_mp.sv
// Multi-port register bank: three combinational read ports, a general write port and a jal link port.
// Sequential clear sweep on reset or Clear; REGBANK_BYPASS_EN enables same-cycle write-to-read forwarding.
module register_bank_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int LINK_REG   = 31,
   parameter int ZERO_REG   = 1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Clear,
   input  logic                  Write,
   input  logic [ADDR_WIDTH-1:0] AddrWrite,
   input  logic [DATA_WIDTH-1:0] DataIn,
   input  logic                  jal,
   input  logic [DATA_WIDTH-1:0] ProgramCounter,
   input  logic [ADDR_WIDTH-1:0] Addr1,
   input  logic [ADDR_WIDTH-1:0] Addr2,
   input  logic [ADDR_WIDTH-1:0] Addr3,
   output logic [DATA_WIDTH-1:0] Data1,
   output logic [DATA_WIDTH-1:0] Data2,
   output logic [DATA_WIDTH-1:0] Data3,
   output logic                  Ready
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LINK_ADDR = ADDR_WIDTH'(LINK_REG);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic ZERO_EN = (ZERO_REG != 0);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   count;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    accept;
   logic                    wr_en;
   logic                    link_en;
   logic [DATA_WIDTH-1:0]   link_val;
   logic [ADDR_WIDTH-1:0]   raddr [3];
   logic [DATA_WIDTH-1:0]   rdata [3];

   // Effective writes this cycle: a Clear cycle drops both ports, and the general port wins on LINK_REG.
   assign accept   = (state == RUN) && !Clear;
   assign link_val = ProgramCounter + DATA_WIDTH'(1);
   assign wr_en    = accept && Write && !(ZERO_EN && (AddrWrite == '0));
   assign link_en  = accept && jal && !(ZERO_EN && (LINK_ADDR == '0))
                     && !(Write && (AddrWrite == LINK_ADDR));

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= CLEAR;
         count <= '0;
         Ready <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               count <= count + ADDR_WIDTH'(1);
               if (count == LAST_ADDR) begin
                  state <= RUN;
                  Ready <= 1'b1;
                  count <= '0;
               end
            end
            RUN: begin
               if (Clear) begin
                  state <= CLEAR;
                  count <= '0;
                  Ready <= 1'b0;
               end
            end
            default: begin
               state <= CLEAR;
               count <= '0;
               Ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         if (state == CLEAR) begin
            mem[count] <= '0;
         end else begin
            if (link_en) mem[LINK_ADDR] <= link_val;
            if (wr_en)   mem[AddrWrite] <= DataIn;
         end
      end
   end

   assign raddr[0] = Addr1;
   assign raddr[1] = Addr2;
   assign raddr[2] = Addr3;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         rdata[i] = '0;
         if ((state == RUN) && !(ZERO_EN && (raddr[i] == '0))) begin
            rdata[i] = mem[raddr[i]];
`ifdef REGBANK_BYPASS_EN
            if (link_en && (raddr[i] == LINK_ADDR)) rdata[i] = link_val;
            if (wr_en && (raddr[i] == AddrWrite))   rdata[i] = DataIn;
`endif
         end
      end
   end

   assign Data1 = rdata[0];
   assign Data2 = rdata[1];
   assign Data3 = rdata[2];

endmodule

// File: tb/tb_register_bank_mp.sv
// Bench for register_bank_mp: clear sweeps, table-driven write/read vectors, and same-cycle corner cases.
module tb_register_bank_mp;

   logic        Clock = 1'b0;
   logic        Reset, Clear, Write, jal;
   logic [4:0]  AddrWrite, Addr1, Addr2, Addr3;
   logic [31:0] DataIn, ProgramCounter;
   logic [31:0] Data1, Data2, Data3;
   logic        Ready;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        wr;
      logic [4:0]  aw;
      logic [31:0] din;
      logic        jl;
      logic [31:0] pc;
      logic [4:0]  a1, a2, a3;
      logic [31:0] e1, e2, e3;
   } vec_t;

   vec_t vecs[10];

   register_bank_mp dut (
      .Clock(Clock), .Reset(Reset), .Clear(Clear), .Write(Write),
      .AddrWrite(AddrWrite), .DataIn(DataIn), .jal(jal),
      .ProgramCounter(ProgramCounter), .Addr1(Addr1), .Addr2(Addr2), .Addr3(Addr3),
      .Data1(Data1), .Data2(Data2), .Data3(Data3), .Ready(Ready)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      Write = 1'b0;
      jal   = 1'b0;
      Clear = 1'b0;
   endtask

   task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
      Addr1 = a1;
      Addr2 = a2;
      Addr3 = a3;
      #1;
   endtask

   // Counts edges until Ready rises; a count of 100 means it never rose.
   task automatic wait_ready(output int n);
      n = 0;
      while (n < 100) begin
         tick();
         n++;
         if (Ready === 1'b1) break;
      end
   endtask

   task automatic read_all_zero(input string name);
      for (int a = 0; a < 32; a += 3) begin
         set_reads(5'(a), 5'((a + 1) % 32), 5'((a + 2) % 32));
         check(name, Data1 | Data2 | Data3, 32'h0);
      end
   endtask

   initial begin
      int n;
      logic [31:0] same_exp;

      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0,        5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 32'h00000040, 5'd31, 5'd5,  5'd0,  32'h00000041, 32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 32'hFFFFFFFF, 5'd31, 5'd31, 5'd5,  32'h0,        32'h0,        32'hDEADBEEF};
      vecs[3] = '{1'b1, 5'd31, 32'h12345678, 1'b1, 32'h00000010, 5'd31, 5'd5,  5'd0,  32'h12345678, 32'hDEADBEEF, 32'h0};
      vecs[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 32'h0,        5'd0,  5'd0,  5'd31, 32'h0,        32'h0,        32'h12345678};
      vecs[5] = '{1'b1, 5'd10, 32'hA5A5A5A5, 1'b1, 32'h00000100, 5'd10, 5'd31, 5'd5,  32'hA5A5A5A5, 32'h00000101, 32'hDEADBEEF};
      vecs[6] = '{1'b1, 5'd1,  32'h00000011, 1'b0, 32'h0,        5'd1,  5'd10, 5'd31, 32'h00000011, 32'hA5A5A5A5, 32'h00000101};
      vecs[7] = '{1'b1, 5'd2,  32'h00000022, 1'b0, 32'h0,        5'd2,  5'd1,  5'd0,  32'h00000022, 32'h00000011, 32'h0};
      vecs[8] = '{1'b1, 5'd3,  32'h00000033, 1'b0, 32'h0,        5'd3,  5'd2,  5'd1,  32'h00000033, 32'h00000022, 32'h00000011};
      vecs[9] = '{1'b1, 5'd4,  32'h00000044, 1'b0, 32'h0,        5'd4,  5'd3,  5'd0,  32'h00000044, 32'h00000033, 32'h0};

      // Reset for two cycles, then a sweep with Write held high throughout
      Reset = 1'b1; idle(); AddrWrite = '0; DataIn = '0; ProgramCounter = '0;
      set_reads(5'd0, 5'd1, 5'd2);
      tick(); tick();
      check("reset_ready", {31'b0, Ready}, 32'h0);
      check("reset_data", Data1 | Data2 | Data3, 32'h0);
      Reset = 1'b0;
      Write = 1'b1; AddrWrite = 5'd7; DataIn = 32'hAAAA5555;
      wait_ready(n);
      check("sweep_edges", 32'(n), 32'd32);
      idle();
      read_all_zero("sweep_zero");

      // Table vectors: writes land on the edge, stored values read back the next cycle
      foreach (vecs[i]) begin
         Write = vecs[i].wr; AddrWrite = vecs[i].aw; DataIn = vecs[i].din;
         jal = vecs[i].jl; ProgramCounter = vecs[i].pc;
         exp_q.push_back(vecs[i].e1);
         exp_q.push_back(vecs[i].e2);
         exp_q.push_back(vecs[i].e3);
         tick();
         idle();
         set_reads(vecs[i].a1, vecs[i].a2, vecs[i].a3);
         check($sformatf("vec%0d_d1", i), Data1, exp_q.pop_front());
         check($sformatf("vec%0d_d2", i), Data2, exp_q.pop_front());
         check($sformatf("vec%0d_d3", i), Data3, exp_q.pop_front());
      end

      // Same-cycle read of a general write (entry 20 currently 0)
      Write = 1'b1; AddrWrite = 5'd20; DataIn = 32'h0BADF00D;
      set_reads(5'd20, 5'd20, 5'd20);
`ifdef REGBANK_BYPASS_EN
      same_exp = 32'h0BADF00D;
`else
      same_exp = 32'h0;
`endif
      check("same_cycle_write", Data1, same_exp);
      tick(); idle(); #1;
      check("after_edge_write", Data2, 32'h0BADF00D);

      // Same-cycle zero-register write is never forwarded
      Write = 1'b1; AddrWrite = 5'd0; DataIn = 32'hFFFFFFFF;
      set_reads(5'd0, 5'd0, 5'd0);
      check("zero_same_cycle", Data1, 32'h0);
      tick(); idle(); #1;
      check("zero_after_edge", Data1, 32'h0);

      // Same-cycle link write and general-over-link priority (entry 31 holds 0x101)
      jal = 1'b1; ProgramCounter = 32'h00000007;
      set_reads(5'd31, 5'd31, 5'd31);
`ifdef REGBANK_BYPASS_EN
      same_exp = 32'h00000008;
`else
      same_exp = 32'h00000101;
`endif
      check("link_same_cycle", Data2, same_exp);
      Write = 1'b1; AddrWrite = 5'd31; DataIn = 32'hCAFE0001; #1;
`ifdef REGBANK_BYPASS_EN
      same_exp = 32'hCAFE0001;
`else
      same_exp = 32'h00000101;
`endif
      check("link_prio_same_cycle", Data3, same_exp);
      tick(); idle(); #1;
      check("link_prio_after_edge", Data3, 32'hCAFE0001);

      // Clear with a concurrent write to entry 4: the write is dropped and not forwarded
      Clear = 1'b1; Write = 1'b1; AddrWrite = 5'd4; DataIn = 32'h00000099;
      set_reads(5'd4, 5'd3, 5'd1);
      check("clear_no_bypass", Data1, 32'h00000044);
      tick(); idle(); #1;
      check("clear_ready_low", {31'b0, Ready}, 32'h0);
      check("clear_forced_zero", Data2, 32'h0);
      n = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         n++;
      end
      Clear = 1'b1;  // ignored during the sweep
      tick(); n++;
      Clear = 1'b0;
      while (n < 100 && Ready !== 1'b1) begin
         tick();
         n++;
      end
      check("clear_sweep_edges", 32'(n), 32'd32);
      set_reads(5'd1, 5'd2, 5'd3);
      check("clear_e1_3", Data1 | Data2 | Data3, 32'h0);
      set_reads(5'd4, 5'd10, 5'd31);
      check("clear_e4_10_31", Data1 | Data2 | Data3, 32'h0);

      // Reset on sweep edge 10 restarts the sweep
      Write = 1'b1; AddrWrite = 5'd8; DataIn = 32'h00000088;
      tick(); idle();
      Clear = 1'b1;
      tick(); idle();
      for (int k = 0; k < 9; k++) tick();
      check("midsweep_ready_low", {31'b0, Ready}, 32'h0);
      Reset = 1'b1;
      tick(); tick();
      Reset = 1'b0;
      wait_ready(n);
      check("reset_restart_edges", 32'(n), 32'd32);
      set_reads(5'd8, 5'd8, 5'd0);
      check("restart_e8", Data1, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
